// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and opcode classifiers shared with the aluN datapath
package alu_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX, ST_DONE} state_t;
  function automatic logic is_arith(input logic [3:0] op);
    return op == ALU_ADD || op == ALU_SUB || op == ALU_SLT;
  endfunction
  function automatic logic is_legal(input logic [3:0] op);
    return is_arith(op) || op == ALU_AND || op == ALU_OR || op == ALU_NOR;
  endfunction
endpackage

// File: rtl/alu_serie_slice.sv
// alu_serie_slice: 1-bit ALU slice (a, b, binv, cin, set_i, ope -> res, cout, set_o); set_o is the raw sum bit
module alu_serie_slice
  import alu_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       binv_i,
  input  logic       cin_i,
  input  logic       set_i,
  input  logic [3:0] ope_i,
  output logic       res_o,
  output logic       cout_o,
  output logic       set_o
);
  logic bb, sum;
  always_comb begin
    bb = b_i ^ binv_i;
    sum = a_i ^ bb ^ cin_i;
    cout_o = (a_i & bb) | (a_i & cin_i) | (bb & cin_i);
    set_o = sum;
    res_o = ope_i == ALU_AND ? a_i & bb :
            ope_i == ALU_OR  ? a_i | bb :
            (ope_i == ALU_ADD || ope_i == ALU_SUB) ? sum :
            ope_i == ALU_SLT ? set_i :
            ope_i == ALU_NOR ? ~(a_i | bb) : 1'b0;
  end
endmodule

// File: rtl/alu_serie.sv
// alu_serie: bit-serial ALU, one slice per clock LSB first; operands in via valid_i/ready_o, result out via valid_o/ready_i
module alu_serie
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [N-1:0] A_i,
  input  logic [N-1:0] B_i,
  input  logic         c_i,
  input  logic [3:0]   ope_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic [N-1:0] sal_o,
  output logic         c_o,
  output logic         err_o,
  output logic         valid_o,
  input  logic         ready_i
);
  localparam int CW = $clog2(N);
  state_t state_q, state_d;
  logic [N-1:0] a_q, b_q, res_q;
  logic [3:0] ope_q;
  logic [CW-1:0] cnt_q;
  logic inv_q, cy_q, sign_q, co_q, err_q;
  logic bit_s, cout_s, set_s, last;
  assign last = cnt_q == CW'(N - 1);
  assign ready_o = state_q == ST_IDLE;
  assign valid_o = state_q == ST_DONE;
  assign sal_o = res_q;
  assign c_o = co_q;
  assign err_o = err_q;
  alu_serie_slice u_slice (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .binv_i(inv_q),
    .cin_i (cy_q),
    .set_i (1'b0),
    .ope_i (ope_q),
    .res_o (bit_s),
    .cout_o(cout_s),
    .set_o (set_s)
  );
  always_ff @(posedge clk_i)
    state_q <= !rst_n_i ? ST_IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = valid_i ? ST_CALC : ST_IDLE;
      ST_CALC: state_d = !last ? ST_CALC : ope_q == ALU_SLT ? ST_FIX : ST_DONE;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ready_i ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      ope_q <= '0;
      cnt_q <= '0;
      inv_q <= 1'b0;
      cy_q <= 1'b0;
      sign_q <= 1'b0;
      co_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && valid_i) begin
        a_q <= A_i;
        b_q <= B_i;
        ope_q <= ope_i;
        inv_q <= c_i;
        cy_q <= c_i;
        cnt_q <= '0;
        co_q <= 1'b0;
        err_q <= !is_legal(ope_i);
      end
      if (state_q == ST_CALC) begin
        a_q <= a_q >> 1;
        b_q <= b_q >> 1;
        res_q <= {bit_s, res_q[N-1:1]};
        cy_q <= cout_s;
        cnt_q <= last ? cnt_q : cnt_q + CW'(1);
        if (last) begin
          co_q <= is_arith(ope_q) & cout_s;
          sign_q <= set_s;
        end
      end
      if (state_q == ST_FIX)
        res_q <= N'(sign_q);
    end
  end
endmodule

// File: tb/tb_alu_serie.sv
// tb_alu_serie: directed and random checks of alu_serie against an arithmetic reference model
module tb_alu_serie;
  import alu_pkg::*;
  localparam int N = 32;
  logic clk_i = 1'b0, rst_n_i = 1'b0;
  logic [N-1:0] A_i = '0, B_i = '0;
  logic c_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
  logic [3:0] ope_i = '0;
  logic ready_o, c_o, err_o, valid_o;
  logic [N-1:0] sal_o;
  int checks = 0, errors = 0;
  alu_serie #(.N(N)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .A_i(A_i), .B_i(B_i), .c_i(c_i), .ope_i(ope_i),
    .valid_i(valid_i), .ready_o(ready_o), .sal_o(sal_o), .c_o(c_o), .err_o(err_o),
    .valid_o(valid_o), .ready_i(ready_i)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Returns {err, carry, result} computed straight from the opcode definitions.
  function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic c, input logic [3:0] op);
    logic [N-1:0] bb;
    logic [N:0] s;
    bb = c ? ~b : b;
    s = {1'b0, a} + {1'b0, bb} + (N+1)'(c);
    case (op)
      ALU_AND: return {2'b00, a & bb};
      ALU_OR:  return {2'b00, a | bb};
      ALU_ADD, ALU_SUB: return {1'b0, s[N], s[N-1:0]};
      ALU_SLT: return {1'b0, s[N], N'(s[N-1])};
      ALU_NOR: return {2'b00, ~(a | bb)};
      default: return {1'b1, 1'b0, {N{1'b0}}};
    endcase
  endfunction
  task automatic start(input logic [N-1:0] a, input logic [N-1:0] b, input logic c, input logic [3:0] op);
    int k = 0;
    @(negedge clk_i);
    A_i = a; B_i = b; c_i = c; ope_i = op; valid_i = 1'b1;
    while (!ready_o && k < 100) begin @(negedge clk_i); k++; end
    @(negedge clk_i);
    valid_i = 1'b0;
    A_i = $urandom; B_i = $urandom; c_i = 1'($urandom); ope_i = 4'($urandom);
  endtask
  // Called at the negedge after the accept edge; returns at the negedge where valid_o is seen.
  task automatic wait_result(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic c, input logic [3:0] op);
    logic [N+1:0] m;
    int cyc = 0;
    m = model(a, b, c, op);
    while (!valid_o && cyc < 100) begin @(negedge clk_i); cyc++; end
    chk({tag, " latency"}, 64'(cyc), op == ALU_SLT ? 64'(N + 1) : 64'(N));
    chk({tag, " sal"}, 64'(sal_o), 64'(m[N-1:0]));
    chk({tag, " c_o"}, 64'(c_o), 64'(m[N]));
    chk({tag, " err"}, 64'(err_o), 64'(m[N+1]));
    chk({tag, " ready_o busy"}, 64'(ready_o), 64'd0);
  endtask
  task automatic release_result(input string tag);
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    chk({tag, " valid_o drop"}, 64'(valid_o), 64'd0);
    chk({tag, " ready_o back"}, 64'(ready_o), 64'd1);
  endtask
  task automatic run(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                     input logic c, input logic [3:0] op);
    start(a, b, c, op);
    wait_result(tag, a, b, c, op);
    release_result(tag);
  endtask
  initial begin
    logic [N-1:0] held, ra, rb;
    logic [3:0] ops [6] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR};
    logic [3:0] rop;
    logic rc;
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    chk("reset ready_o", 64'(ready_o), 64'd1);
    chk("reset valid_o", 64'(valid_o), 64'd0);
    chk("reset sal_o", 64'(sal_o), 64'd0);
    chk("reset c_o", 64'(c_o), 64'd0);
    chk("reset err_o", 64'(err_o), 64'd0);
    run("add ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, ALU_ADD);
    chk("add ovf literal", 64'(sal_o), 64'h8000_0000);
    run("sub 5-7", 32'd5, 32'd7, 1'b1, ALU_SUB);
    chk("sub 5-7 literal", 64'(sal_o), 64'hFFFF_FFFE);
    run("sub 7-5", 32'd7, 32'd5, 1'b1, ALU_SUB);
    chk("sub 7-5 literal", 64'({c_o, sal_o}), 64'h1_0000_0002);
    run("slt 3<9", 32'd3, 32'd9, 1'b1, ALU_SLT);
    chk("slt 3<9 literal", 64'(sal_o), 64'd1);
    run("slt 9<3", 32'd9, 32'd3, 1'b1, ALU_SLT);
    run("nor 0 0", 32'd0, 32'd0, 1'b0, ALU_NOR);
    chk("nor literal", 64'(sal_o), 64'hFFFF_FFFF);
    run("illegal", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 4'b1111);
    chk("illegal literal", 64'({err_o, sal_o}), 64'h1_0000_0000);
    run("and", 32'hF0F0_1234, 32'hFF00_FF00, 1'b0, ALU_AND);
    run("or", 32'hF0F0_1234, 32'h0F00_0001, 1'b0, ALU_OR);
    start(32'hDEAD_BEEF, 32'h0123_4567, 1'b0, ALU_ADD);
    wait_result("bp", 32'hDEAD_BEEF, 32'h0123_4567, 1'b0, ALU_ADD);
    held = sal_o;
    for (int i = 0; i < 10; i++) begin
      A_i = $urandom; B_i = $urandom; ope_i = ALU_SUB; valid_i = 1'b1;
      @(negedge clk_i);
      chk("bp valid_o", 64'(valid_o), 64'd1);
      chk("bp ready_o", 64'(ready_o), 64'd0);
      chk("bp sal hold", 64'(sal_o), 64'(held));
    end
    A_i = 32'd100; B_i = 32'd58; c_i = 1'b1; ope_i = ALU_SUB;
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    chk("bp release ready_o", 64'(ready_o), 64'd1);
    @(negedge clk_i);
    valid_i = 1'b0;
    A_i = $urandom; B_i = $urandom;
    wait_result("bp next", 32'd100, 32'd58, 1'b1, ALU_SUB);
    chk("bp next literal", 64'(sal_o), 64'd42);
    release_result("bp next");
    start(32'hFFFF_0000, 32'h0000_FFFF, 1'b0, ALU_ADD);
    repeat (14) @(negedge clk_i);
    rst_n_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    chk("midreset ready_o", 64'(ready_o), 64'd1);
    chk("midreset valid_o", 64'(valid_o), 64'd0);
    chk("midreset sal_o", 64'(sal_o), 64'd0);
    chk("midreset c_o", 64'(c_o), 64'd0);
    run("post reset add", 32'd2, 32'd3, 1'b0, ALU_ADD);
    chk("post reset literal", 64'(sal_o), 64'd5);
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom);
      rop = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ops[$urandom_range(0, 5)];
      if (i % 8 == 0) rb = ra;
      run("random", ra, rb, rc, rop);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
